// File: rtl/md_sequencer.sv
// md_sequencer
// Sequencing controller for the multiply/divide unit of the pipelined CPU.
// Launches the arithmetic datapath for mult/multu/div/divu, tracks the fixed
// latency with a 4-bit down-counter, generates the HI/LO write strobes and
// produces the Decode-stage stall for multiply/divide-class instructions.
//
// State table:
//   state  | meaning
//   IDLE   | no operation in flight, E-stage MD ops are accepted
//   MUL    | mult/multu in flight, cnt counts remaining busy cycles
//   DIV    | div/divu in flight (possibly a zero-divisor divide), cnt counts down
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   md_op_e     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9..15 none
//   d2_zero_e   E-stage divisor equals zero
//   md_class_d  D-stage instruction is multiply/divide-class
//   dp_start    one-cycle datapath launch pulse
//   dp_op       datapath op at launch: 0 mult, 1 multu, 2 div, 3 divu
//   res_we      one-cycle strobe latching the datapath result into HI/LO
//   hi_we       mthi write strobe
//   lo_we       mtlo write strobe
//   hilo_sel    read mux select, 0 HI, 1 LO
//   busy        an operation is in flight (registered)
//   stall       freeze PC and F/D, bubble D->E
//   md_err      sticky protocol-violation flag (MD op issued while busy)

module md_sequencer #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] md_op_e,
  input  logic       d2_zero_e,
  input  logic       md_class_d,
  output logic       dp_start,
  output logic [1:0] dp_op,
  output logic       res_we,
  output logic       hi_we,
  output logic       lo_we,
  output logic       hilo_sel,
  output logic       busy,
  output logic       stall,
  output logic       md_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       nores_q, nores_d;   // current op is a zero-divisor divide
  logic       err_q, err_d;

  logic op_mul, op_div, op_md, op_any;

  assign op_mul = (md_op_e == 4'd1) || (md_op_e == 4'd2);
  assign op_div = (md_op_e == 4'd3) || (md_op_e == 4'd4);
  assign op_md  = op_mul || op_div;
  assign op_any = (md_op_e >= 4'd1) && (md_op_e <= 4'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      nores_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nores_q <= nores_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nores_d  = nores_q;
    err_d    = err_q;
    dp_start = 1'b0;
    // 1..4 map to 0..3 by subtracting one in the low two bits (4 -> 0-1 = 3)
    dp_op    = md_op_e[1:0] - 2'd1;
    res_we   = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (op_mul) begin
          dp_start = 1'b1;
          state_d  = S_MUL;
          cnt_d    = MUL_CNT;
          nores_d  = 1'b0;
        end else if (op_div) begin
          // a zero-divisor divide burns the full latency without touching HI/LO
          dp_start = !d2_zero_e;
          state_d  = S_DIV;
          cnt_d    = DIV_CNT;
          nores_d  = d2_zero_e;
        end else if (md_op_e == 4'd5) begin
          hi_we = 1'b1;
        end else if (md_op_e == 4'd6) begin
          lo_we = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        if (op_any) begin
          err_d = 1'b1;
        end
        if (cnt_q <= 4'd1) begin
          res_we  = !nores_q;
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // nothing launches or commits in a reset cycle; the aborted op leaves HI/LO alone
    if (reset) begin
      dp_start = 1'b0;
      res_we   = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = md_class_d && (busy || op_md);
  assign hilo_sel = (md_op_e == 4'd8);
  assign md_err   = err_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] md_op_e;
  logic       d2_zero_e;
  logic       md_class_d;
  logic       dp_start;
  logic [1:0] dp_op;
  logic       res_we;
  logic       hi_we;
  logic       lo_we;
  logic       hilo_sel;
  logic       busy;
  logic       stall;
  logic       md_err;

  int errors = 0;
  int checks = 0;

  md_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_op_e    (md_op_e),
    .d2_zero_e  (d2_zero_e),
    .md_class_d (md_class_d),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .res_we     (res_we),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hilo_sel   (hilo_sel),
    .busy       (busy),
    .stall      (stall),
    .md_err     (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well away from either edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; md_op_e = 4'd1; d2_zero_e = 1'b0; md_class_d = 1'b0;

    // reset held with mult pending in E
    nxt(); settle();
    chk("rst_dp_start", {3'b0, dp_start}, 4'd0);
    chk("rst_busy",     {3'b0, busy},     4'd0);
    chk("rst_err",      {3'b0, md_err},   4'd0);
    nxt(); settle();
    chk("rst_dp_start2", {3'b0, dp_start}, 4'd0);
    chk("rst_busy2",     {3'b0, busy},     4'd0);

    // idle after reset
    nxt(); reset = 1'b0; md_op_e = 4'd0; settle();
    chk("idle_dp_start", {3'b0, dp_start}, 4'd0);
    chk("idle_res_we",   {3'b0, res_we},   4'd0);
    chk("idle_hi_we",    {3'b0, hi_we},    4'd0);
    chk("idle_lo_we",    {3'b0, lo_we},    4'd0);
    chk("idle_stall",    {3'b0, stall},    4'd0);
    chk("idle_hilo_sel", {3'b0, hilo_sel}, 4'd0);
    chk("idle_busy",     {3'b0, busy},     4'd0);

    // mult launch, latency 5
    nxt(); md_op_e = 4'd1; settle();
    chk("mul_dp_start", {3'b0, dp_start}, 4'd1);
    chk("mul_dp_op",    {2'b0, dp_op},    4'd0);
    chk("mul_busy0",    {3'b0, busy},     4'd0);
    for (int k = 1; k <= 5; k++) begin
      nxt(); md_op_e = 4'd0; settle();
      chk("mul_busy",   {3'b0, busy},     4'd1);
      chk("mul_res_we", {3'b0, res_we},   (k == 5) ? 4'd1 : 4'd0);
      chk("mul_nostart",{3'b0, dp_start}, 4'd0);
    end
    nxt(); settle();
    chk("mul_done_busy",   {3'b0, busy},   4'd0);
    chk("mul_done_res_we", {3'b0, res_we}, 4'd0);

    // multu op code mapping
    nxt(); md_op_e = 4'd2; settle();
    chk("multu_dp_op", {2'b0, dp_op}, 4'd1);
    for (int k = 1; k <= 5; k++) begin
      nxt(); md_op_e = 4'd0; settle();
    end
    nxt(); settle();
    chk("multu_done_busy", {3'b0, busy}, 4'd0);

    // divu with an MD instruction waiting in D, latency 10
    nxt(); md_op_e = 4'd4; md_class_d = 1'b1; settle();
    chk("divu_dp_start", {3'b0, dp_start}, 4'd1);
    chk("divu_dp_op",    {2'b0, dp_op},    4'd3);
    chk("divu_stall0",   {3'b0, stall},    4'd1);
    for (int k = 1; k <= 10; k++) begin
      nxt(); md_op_e = 4'd0; settle();
      chk("divu_stall",  {3'b0, stall},  4'd1);
      chk("divu_busy",   {3'b0, busy},   4'd1);
      chk("divu_res_we", {3'b0, res_we}, (k == 10) ? 4'd1 : 4'd0);
    end
    nxt(); settle();
    chk("divu_stall_rel", {3'b0, stall}, 4'd0);
    chk("divu_busy_rel",  {3'b0, busy},  4'd0);
    md_class_d = 1'b0;

    // div with zero divisor: full latency, no launch, no result write
    nxt(); md_op_e = 4'd3; d2_zero_e = 1'b1; settle();
    chk("dz_dp_start", {3'b0, dp_start}, 4'd0);
    chk("dz_stall",    {3'b0, stall},    4'd0);
    for (int k = 1; k <= 10; k++) begin
      nxt(); md_op_e = 4'd0; d2_zero_e = 1'b0; settle();
      chk("dz_busy",   {3'b0, busy},   4'd1);
      chk("dz_res_we", {3'b0, res_we}, 4'd0);
    end
    nxt(); settle();
    chk("dz_done_busy", {3'b0, busy}, 4'd0);

    // div with nonzero divisor
    nxt(); md_op_e = 4'd3; settle();
    chk("div_dp_start", {3'b0, dp_start}, 4'd1);
    chk("div_dp_op",    {2'b0, dp_op},    4'd2);
    for (int k = 1; k <= 10; k++) begin
      nxt(); md_op_e = 4'd0; settle();
      chk("div_res_we", {3'b0, res_we}, (k == 10) ? 4'd1 : 4'd0);
    end

    // mthi / mtlo / mflo / mfhi while idle
    nxt(); md_op_e = 4'd5; settle();
    chk("mthi_hi_we", {3'b0, hi_we}, 4'd1);
    chk("mthi_lo_we", {3'b0, lo_we}, 4'd0);
    nxt(); md_op_e = 4'd0; settle();
    chk("mthi_hi_off", {3'b0, hi_we}, 4'd0);
    chk("mthi_busy",   {3'b0, busy},  4'd0);
    nxt(); md_op_e = 4'd6; settle();
    chk("mtlo_lo_we", {3'b0, lo_we}, 4'd1);
    chk("mtlo_hi_we", {3'b0, hi_we}, 4'd0);
    nxt(); md_op_e = 4'd8; md_class_d = 1'b1; settle();
    chk("mflo_sel",   {3'b0, hilo_sel}, 4'd1);
    chk("mflo_stall", {3'b0, stall},    4'd0);
    nxt(); md_op_e = 4'd7; md_class_d = 1'b0; settle();
    chk("mfhi_sel",  {3'b0, hilo_sel}, 4'd0);
    chk("mflo_busy", {3'b0, busy},     4'd0);
    nxt(); md_op_e = 4'd12; settle();
    chk("op12_start", {3'b0, dp_start}, 4'd0);
    nxt(); md_op_e = 4'd0; settle();
    chk("op12_busy", {3'b0, busy}, 4'd0);

    // reset pulse during mult aborts it
    nxt(); md_op_e = 4'd1; settle();
    chk("rmid_start", {3'b0, dp_start}, 4'd1);
    nxt(); md_op_e = 4'd0; settle();
    chk("rmid_busy1", {3'b0, busy}, 4'd1);
    nxt(); reset = 1'b1; settle();
    chk("rmid_res_we_rst", {3'b0, res_we}, 4'd0);
    for (int k = 3; k <= 10; k++) begin
      nxt(); reset = 1'b0; settle();
      chk("rmid_busy",   {3'b0, busy},   4'd0);
      chk("rmid_res_we", {3'b0, res_we}, 4'd0);
    end

    // MD ops issued while busy: dropped, md_err sticky, count unaffected
    nxt(); md_op_e = 4'd1; settle();
    chk("err_start", {3'b0, dp_start}, 4'd1);
    nxt(); md_op_e = 4'd0; settle();
    chk("err_pre", {3'b0, md_err}, 4'd0);
    nxt(); md_op_e = 4'd1; settle();
    chk("err_drop_start", {3'b0, dp_start}, 4'd0);
    nxt(); md_op_e = 4'd5; settle();
    chk("err_set",     {3'b0, md_err}, 4'd1);
    chk("err_busy",    {3'b0, busy},   4'd1);
    chk("err_hi_drop", {3'b0, hi_we},  4'd0);
    nxt(); md_op_e = 4'd0; settle();
    chk("err_res_we4", {3'b0, res_we}, 4'd0);
    // result cycle collides with a new mult: result still written, op dropped
    nxt(); md_op_e = 4'd2; settle();
    chk("err_res_we5",  {3'b0, res_we},   4'd1);
    chk("coll_nostart", {3'b0, dp_start}, 4'd0);
    nxt(); md_op_e = 4'd0; settle();
    chk("err_done_busy", {3'b0, busy},   4'd0);
    chk("err_hold",      {3'b0, md_err}, 4'd1);
    nxt(); settle();
    chk("err_hold2", {3'b0, md_err}, 4'd1);

    // reset clears the sticky flag
    nxt(); reset = 1'b1; settle();
    nxt(); reset = 1'b0; settle();
    chk("err_clr", {3'b0, md_err}, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Sequencing controller for the multiply/divide resource of the pipelined CPU. It accepts multiply/divide-class operations issued from the Execute stage and starts the arithmetic datapath. It tracks the datapath's fixed latency, generates the HI/LO write strobes, and raises the Decode-stage stall whenever a multiply/divide-class instruction would collide with an operation still in flight. It replaces the ad-hoc `busy & (mult|…|mflo)` gating currently spread across the top level with one registered state machine.

## Interface
Parameters:
- `MUL_LAT`, default 5: busy cycles for mult/multu (1..15).
- `DIV_LAT`, default 10: busy cycles for div/divu (1..15).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `md_op_e`  in  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none.
- `d2_zero_e`  in  1  E-stage divisor (rt value) equals zero.
- `md_class_d`  in  1  instruction in D is one of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `dp_start`  out  1  one-cycle pulse that launches the datapath.
- `dp_op`  out  2  datapath op at launch: 0 mult, 1 multu, 2 div, 3 divu.
- `res_we`  out  1  one-cycle strobe that latches the datapath result into HI and LO.
- `hi_we`  out  1  mthi write strobe.
- `lo_we`  out  1  mtlo write strobe.
- `hilo_sel`  out  1  read mux select: 0 HI (mfhi), 1 LO (mflo).
- `busy`  out  1  an operation is in flight (registered).
- `stall`  out  1  freeze PC and the F/D register, and bubble D→E.
- `md_err`  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, MUL, DIV. A 4-bit down-counter `cnt` runs alongside the state.
- IDLE with `md_op_e` ∈ {1,2}: `dp_start`=1, `dp_op`=`md_op_e`−1, next state MUL, `cnt`←`MUL_LAT`.
- IDLE with `md_op_e` ∈ {3,4} and `d2_zero_e`=0: `dp_start`=1, `dp_op`=`md_op_e`−1, next state DIV, `cnt`←`DIV_LAT`.
- IDLE with `md_op_e` ∈ {3,4} and `d2_zero_e`=1: `dp_start`=0, next state DIV, `cnt`←`DIV_LAT`. The full latency is still consumed, but `res_we` is suppressed, so HI/LO are left unchanged (MIPS-undefined result).
- MUL or DIV: `cnt` decrements each cycle. On the cycle with `cnt`==1, `res_we`=1 (unless the op was a zero-divisor divide) and the next state is IDLE.
- mthi/mtlo in IDLE: `hi_we` or `lo_we` is 1 in the same cycle (combinational from `md_op_e`). No state change.
- mfhi/mflo: `hilo_sel` = (`md_op_e`==8). No state change.
- `busy` = (state ≠ IDLE).
- `stall` = `md_class_d` & (`busy` | `md_op_e` ∈ {1,2,3,4}). This covers the launch cycle, so a back-to-back MD instruction waits for completion.
- Any `md_op_e` ∈ 1..8 while `busy`=1 is a hazard-unit bug. The op is ignored: no strobes, no state change. `md_err` is set and held until reset.
- All outputs are functions of the current state and current inputs. No output depends on `clk` other than through registers.

## Timing
- Reset values: state IDLE, `cnt`=0, `busy`=0, `md_err`=0. With `md_op_e`=0 after reset, `dp_start`, `res_we`, `hi_we`, `lo_we`, `stall` and `hilo_sel` are all 0.
- Launch in cycle t:
  - `dp_start` is high in cycle t.
  - `busy` is high in cycles t+1 … t+LAT.
  - `res_we` is high in cycle t+LAT.
  - `busy`=0 from cycle t+LAT+1. An MD instruction stalled in D issues to E in cycle t+LAT+1.
- `stall` is combinational; D-stage instructions are held by it.
- `reset` asserted mid-operation: the next edge forces IDLE and clears `cnt`. No `res_we` is produced for the aborted operation. `dp_start` is suppressed in any cycle where `reset`=1.
- Simultaneous `res_we` and a new op in E cannot legally occur. If it does, `res_we` still fires, the op is dropped and `md_err` is set.
- `cnt` never underflows: it reloads only on launch and stops at 0 in IDLE.

## Test plan
- Reset: `md_op_e`=1 held during reset → `dp_start`=0, `busy`=0, `md_err`=0 while reset is high.
- mult at t=10: `dp_start`@10, `dp_op`=0, `busy`@11–15, `res_we`@15 only, `busy`=0@16.
- divu at t=20 with `md_class_d`=1 for cycles 20–30: `stall`=1@20–30, `res_we`@30, `stall`=0@31.
- div with `d2_zero_e`=1: `dp_start`=0, `busy` for 10 cycles, `res_we` never asserted.
- mthi while idle → `hi_we`=1 in that cycle only. mflo → `hilo_sel`=1, `busy` stays 0.
- mult launched, `reset` pulsed at t+2 → `busy`=0 at t+3, no `res_we` through t+10. A second mult (`md_op_e`=1) injected while busy → `md_err` becomes and stays 1, `cnt` is unaffected.
